pc_fetch_ctrl: RTL

- Sequential consumer of the next-PC selection logic.
- Holds the architectural program counter and drives it to instruction memory.
- Decides each cycle whether the selected next PC is committed, based on run mode (run/step), hazard stall and HALT detection.
- Counts active cycles and reports execution state to the debug unit.

---
 rtl/pc_fetch_ctrl_pkg.sv | 20 ++
 rtl/pc_fetch_ctrl_if.sv | 35 +++
 rtl/pc_fetch_ctrl_sat_counter.sv | 31 +++
 rtl/pc_fetch_ctrl.sv | 91 +++++++++
 4 files changed

// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared fetch-control definitions: state encodings
// and default reset PC, also used by the debug unit.
package pc_fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_STEP   = 2'd2,
    ST_HALTED = 2'd3
  } state_e;

  localparam logic [31:0] RESET_PC_DFLT = 32'h0000_0000;

  function automatic logic is_misaligned(
    input logic [1:0] lsb
  );
    return |lsb;
  endfunction

endpackage

// File: rtl/pc_fetch_ctrl_if.sv
// Fetch-control bus: next-PC, debug commands, hazards in;
// PC, enable, state, sticky flags and cycle count out.
interface pc_fetch_ctrl_if #(
  parameter int NBITS    = 32,
  parameter int CNT_BITS = 32
);
  logic [NBITS-1:0]    i_NextPC;
  logic                i_Run;
  logic                i_Step;
  logic                i_Restart;
  logic                i_Stall;
  logic                i_Halt;
  logic [NBITS-1:0]    o_PC;
  logic                o_PCEnable;
  logic [1:0]          o_State;
  logic                o_Halted;
  logic                o_Misaligned;
  logic [CNT_BITS-1:0] o_CycleCount;

  modport master (
    output i_NextPC, i_Run, i_Step,
    output i_Restart, i_Stall, i_Halt,
    input  o_PC, o_PCEnable, o_State,
    input  o_Halted, o_Misaligned,
    input  o_CycleCount
  );

  modport slave (
    input  i_NextPC, i_Run, i_Step,
    input  i_Restart, i_Stall, i_Halt,
    output o_PC, o_PCEnable, o_State,
    output o_Halted, o_Misaligned,
    output o_CycleCount
  );
endinterface

// File: rtl/pc_fetch_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports: i_clk, i_reset_n, i_inc, i_clr -> count.
module sat_counter #(
  parameter int CNT_BITS = 32
) (
  input  logic                i_clk,
  input  logic                i_reset_n,
  input  logic                i_inc,
  input  logic                i_clr,
  output logic [CNT_BITS-1:0] count
);

  logic [CNT_BITS-1:0] count_q;
  logic [CNT_BITS-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (i_clr)
      count_d = '0;
    else if (i_inc && !(&count_q))
      count_d = count_q + CNT_BITS'(1);
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) count_q <= '0;
    else            count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/pc_fetch_ctrl.sv
// PC register and run/step/halt commit control.
// Ports: i_clk, i_reset_n, bus (slave side of fetch bus).
module pc_fetch_ctrl
  import pc_fetch_ctrl_pkg::*;
#(
  parameter int               NBITS    = 32,
  parameter logic [NBITS-1:0] RESET_PC =
    NBITS'(RESET_PC_DFLT),
  parameter int               CNT_BITS = 32
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  pc_fetch_ctrl_if.slave bus
);

  state_e           state_q, state_d;
  logic [NBITS-1:0] pc_q, pc_d;
  logic             mis_q, mis_d;
  logic             pc_en;
  logic             cnt_inc;
  logic             cnt_clr;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    mis_d   = mis_q;
    pc_en   = 1'b0;
    cnt_inc = 1'b0;
    cnt_clr = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.i_Run)       state_d = ST_RUN;
        else if (bus.i_Step) state_d = ST_STEP;
      end
      ST_RUN: begin
        pc_en   = ~bus.i_Stall & ~bus.i_Halt;
        cnt_inc = 1'b1;
        if (bus.i_Halt) state_d = ST_HALTED;
      end
      ST_STEP: begin
        pc_en   = ~bus.i_Stall & ~bus.i_Halt;
        cnt_inc = 1'b1;
        if (bus.i_Halt) state_d = ST_HALTED;
        else if (pc_en) state_d = ST_IDLE;
      end
      ST_HALTED: begin
        if (bus.i_Restart) begin
          state_d = ST_IDLE;
          pc_d    = RESET_PC;
          mis_d   = 1'b0;
          cnt_clr = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (pc_en) begin
      pc_d = {bus.i_NextPC[NBITS-1:2], 2'b00};
      if (is_misaligned(bus.i_NextPC[1:0]))
        mis_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      mis_q   <= mis_d;
    end
  end

  sat_counter #(
    .CNT_BITS(CNT_BITS)
  ) u_cnt (
    .i_clk    (i_clk),
    .i_reset_n(i_reset_n),
    .i_inc    (cnt_inc),
    .i_clr    (cnt_clr),
    .count    (bus.o_CycleCount)
  );

  assign bus.o_PC         = pc_q;
  assign bus.o_PCEnable   = pc_en;
  assign bus.o_State      = state_q;
  assign bus.o_Halted     = (state_q == ST_HALTED);
  assign bus.o_Misaligned = mis_q;

endmodule
